// File: rtl/result_writer.sv
// Writes the four systolic-array results to the shared scratch memory as sequential byte writes,
// starting at a programmable base address. The results are captured when the transaction starts.
module result_writer #(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_RESULTS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] result_baseaddr,
    input  logic [DATA_W-1:0] c11,
    input  logic [DATA_W-1:0] c12,
    input  logic [DATA_W-1:0] c21,
    input  logic [DATA_W-1:0] c22,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic [DATA_W-1:0] data,
    output logic              busy_o,
    output logic              is_done_o
);

    localparam int unsigned     IDX_W    = $clog2(NUM_RESULTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RESULTS - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] snap_q [NUM_RESULTS];
    logic [DATA_W-1:0] snap_d [NUM_RESULTS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_RESULTS; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            snap_q  <= snap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        busy_d  = busy_q;
        done_d  = done_q;
        snap_d  = snap_q;
        idx_inc = idx_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    snap_d[0] = c11;
                    snap_d[1] = c12;
                    snap_d[2] = c21;
                    snap_d[3] = c22;
                    base_d    = result_baseaddr;
                    idx_d     = '0;
                    addr_d    = result_baseaddr;
                    data_d    = c11;
                    we_d      = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = StWrite;
                end
            end
            StWrite: begin
                // Without a grant every output holds, so the beat stays on the bus.
                if (mem_gnt) begin
                    if (idx_q == LAST_IDX) begin
                        we_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        idx_d  = idx_inc;
                        addr_d = base_q + ADDR_W'(idx_inc);
                        data_d = snap_q[idx_inc];
                    end
                end
            end
            StDone: begin
                // Leaving only on en low keeps a held-high en from retriggering.
                if (!en) begin
                    done_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign addr      = addr_q;
    assign we        = we_q;
    assign data      = data_q;
    assign busy_o    = busy_q;
    assign is_done_o = done_q;

endmodule

// File: tb/tb_result_writer.sv
// Directed bench for result_writer: the basic, wrap, stall, snapshot, reset-abort and
// no-retrigger scenarios, each checked against hand-computed values.
module tb_result_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [5:0] result_baseaddr = '0;
    logic [7:0] c11 = '0, c12 = '0, c21 = '0, c22 = '0;
    logic       mem_gnt = 1'b1;
    logic [5:0] addr;
    logic       we;
    logic [7:0] data;
    logic       busy_o;
    logic       is_done_o;

    int checks = 0;
    int errors = 0;

    result_writer #(
        .ADDR_W     (6),
        .DATA_W     (8),
        .NUM_RESULTS(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .result_baseaddr(result_baseaddr),
        .c11            (c11),
        .c12            (c12),
        .c21            (c21),
        .c22            (c22),
        .mem_gnt        (mem_gnt),
        .addr           (addr),
        .we             (we),
        .data           (data),
        .busy_o         (busy_o),
        .is_done_o      (is_done_o)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({addr, we, data, busy_o, is_done_o} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs addr=%0d we=%b data=%h busy=%b done=%b required all 0",
                     addr, we, data, busy_o, is_done_o);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({we, busy_o, is_done_o} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset we=%b busy=%b done=%b required 000",
                     we, busy_o, is_done_o);
        end
    endtask

    task automatic test_basic();
        logic [5:0] ea [4] = '{6'd10, 6'd11, 6'd12, 6'd13};
        logic [7:0] ed [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        en = 1'b1; result_baseaddr = 6'd10; mem_gnt = 1'b1;
        c11 = 8'h11; c12 = 8'h22; c21 = 8'h33; c22 = 8'h44;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({we, busy_o, is_done_o, addr, data} !== {3'b110, ea[i], ed[i]}) begin
                errors++;
                $display("FAIL basic_beat%0d we=%b busy=%b done=%b addr=%0d data=%h required 110 %0d %h",
                         i, we, busy_o, is_done_o, addr, data, ea[i], ed[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({we, busy_o, is_done_o} !== 3'b001) begin
                errors++;
                $display("FAIL basic_done%0d we=%b busy=%b done=%b required 001",
                         i, we, busy_o, is_done_o);
            end
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if ({we, busy_o, is_done_o, addr, data} !== {3'b000, 6'd13, 8'h44}) begin
            errors++;
            $display("FAIL basic_idle we=%b busy=%b done=%b addr=%0d data=%h required 000 13 44",
                     we, busy_o, is_done_o, addr, data);
        end
    endtask

    task automatic test_wrap();
        logic [5:0] ea [4] = '{6'd62, 6'd63, 6'd0, 6'd1};
        logic [7:0] ed [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
        en = 1'b1; result_baseaddr = 6'd62;
        c11 = 8'd1; c12 = 8'd2; c21 = 8'd3; c22 = 8'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({we, addr, data} !== {1'b1, ea[i], ed[i]}) begin
                errors++;
                $display("FAIL wrap_beat%0d we=%b addr=%0d data=%h required 1 %0d %h",
                         i, we, addr, data, ea[i], ed[i]);
            end
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if ({we, is_done_o} !== 2'b01) begin
            errors++;
            $display("FAIL wrap_done we=%b done=%b required 01", we, is_done_o);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [5:0] ea [7] = '{6'd20, 6'd21, 6'd21, 6'd21, 6'd21, 6'd22, 6'd23};
        logic [7:0] ed [7] = '{8'hA1, 8'hA2, 8'hA2, 8'hA2, 8'hA2, 8'hA3, 8'hA4};
        logic       gv [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        en = 1'b1; result_baseaddr = 6'd20; mem_gnt = 1'b1;
        c11 = 8'hA1; c12 = 8'hA2; c21 = 8'hA3; c22 = 8'hA4;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if ({we, busy_o, addr, data} !== {2'b11, ea[i], ed[i]}) begin
                errors++;
                $display("FAIL stall_cycle%0d we=%b busy=%b addr=%0d data=%h required 11 %0d %h",
                         i, we, busy_o, addr, data, ea[i], ed[i]);
            end
            mem_gnt = gv[i];
        end
        @(negedge clk);
        checks++;
        if ({we, busy_o, is_done_o} !== 3'b001) begin
            errors++;
            $display("FAIL stall_done we=%b busy=%b done=%b required 001", we, busy_o, is_done_o);
        end
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_snapshot();
        logic [5:0] ea [4] = '{6'd30, 6'd31, 6'd32, 6'd33};
        logic [7:0] ed [4] = '{8'h05, 8'h06, 8'h07, 8'h08};
        en = 1'b1; result_baseaddr = 6'd30;
        c11 = 8'h05; c12 = 8'h06; c21 = 8'h07; c22 = 8'h08;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({we, addr, data} !== {1'b1, ea[i], ed[i]}) begin
                errors++;
                $display("FAIL snapshot_beat%0d we=%b addr=%0d data=%h required 1 %0d %h",
                         i, we, addr, data, ea[i], ed[i]);
            end
            c11 = 8'hFF; c12 = 8'hFF; c21 = 8'hFF; c22 = 8'hFF; result_baseaddr = 6'd0;
        end
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        en = 1'b1; result_baseaddr = 6'd40;
        c11 = 8'h21; c12 = 8'h22; c21 = 8'h23; c22 = 8'h24;
        repeat (3) @(negedge clk);
        checks++;
        if ({we, addr, data} !== {1'b1, 6'd42, 8'h23}) begin
            errors++;
            $display("FAIL abort_beat2 we=%b addr=%0d data=%h required 1 42 23", we, addr, data);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({addr, we, data, busy_o, is_done_o} !== 17'd0) begin
            errors++;
            $display("FAIL abort_async addr=%0d we=%b data=%h busy=%b done=%b required all 0",
                     addr, we, data, busy_o, is_done_o);
        end
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({addr, we, data, busy_o, is_done_o} !== 17'd0) begin
            errors++;
            $display("FAIL abort_idle addr=%0d we=%b data=%h busy=%b done=%b required all 0",
                     addr, we, data, busy_o, is_done_o);
        end
        en = 1'b1; result_baseaddr = 6'd50;
        c11 = 8'h31; c12 = 8'h32; c21 = 8'h33; c22 = 8'h34;
        @(negedge clk);
        checks++;
        if ({we, busy_o, addr, data} !== {2'b11, 6'd50, 8'h31}) begin
            errors++;
            $display("FAIL abort_restart0 we=%b busy=%b addr=%0d data=%h required 11 50 31",
                     we, busy_o, addr, data);
        end
        @(negedge clk);
        checks++;
        if ({we, addr, data} !== {1'b1, 6'd51, 8'h32}) begin
            errors++;
            $display("FAIL abort_restart1 we=%b addr=%0d data=%h required 1 51 32", we, addr, data);
        end
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_retrigger();
        int beats = 0;
        en = 1'b1; result_baseaddr = 6'd5;
        c11 = 8'h41; c12 = 8'h42; c21 = 8'h43; c22 = 8'h44;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (we === 1'b1) beats++;
        end
        checks++;
        if (beats !== 4) begin
            errors++;
            $display("FAIL retrigger_beats got %0d write cycles required 4", beats);
        end
        checks++;
        if ({we, busy_o, is_done_o} !== 3'b001) begin
            errors++;
            $display("FAIL retrigger_held we=%b busy=%b done=%b required 001", we, busy_o, is_done_o);
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if ({we, busy_o, is_done_o} !== 3'b000) begin
            errors++;
            $display("FAIL retrigger_idle we=%b busy=%b done=%b required 000", we, busy_o, is_done_o);
        end
        en = 1'b1; result_baseaddr = 6'd8;
        @(negedge clk);
        checks++;
        if ({we, busy_o, addr, data} !== {2'b11, 6'd8, 8'h41}) begin
            errors++;
            $display("FAIL retrigger_second we=%b busy=%b addr=%0d data=%h required 11 8 41",
                     we, busy_o, addr, data);
        end
        repeat (4) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_snapshot();
        test_reset_abort();
        test_no_retrigger();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_writer.md
Name: result_writer

Overview:
- Write-side counterpart of the systolic-mode load path.
- Loaders read weights and features from the shared 64x8 scratch memory. This block writes the four systolic-array results (c11, c12, c21, c22) back to that memory at a programmable base address.
- Captures a result snapshot on start, issues four sequential single-byte writes (stalling on memory grant), then reports completion.
- Drives the memory-side addr/we/data path through the existing mode mux when in write mode.

Parameters:
- ADDR_W, 6, memory address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, result and memory word width.
- NUM_RESULTS, 4, number of write beats per transaction; fixed at 4 for this block.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; 0 resets immediately.
- en  input  1  start/hold level; a transaction starts when sampled 1 in IDLE.
- result_baseaddr  input  ADDR_W  address of the first write (c11).
- c11, c12, c21, c22  input  DATA_W each  systolic-array results; sampled only at start.
- mem_gnt  input  1  memory port grant; a write beat is accepted at an edge only when mem_gnt=1.
- addr  output  ADDR_W  write address (registered).
- we  output  1  write enable (registered); never 1 outside WRITE.
- data  output  DATA_W  write data (registered).
- busy_o  output  1  1 while in WRITE.
- is_done_o  output  1  1 while in DONE.

Behaviour:
- Reset (rst=0, async): state=IDLE, idx=0, addr=0, we=0, data=0, busy_o=0, is_done_o=0, snapshot regs=0.
  - Reset mid-transaction aborts immediately; no further beats; partial writes are not undone.
- State machine: IDLE -> WRITE -> DONE -> IDLE. All outputs are registered from state and index.
- IDLE, at an edge with en=1:
  - Latch c11..c22 into the snapshot and latch result_baseaddr.
  - Set idx=0, addr=base, data=c11, we=1, busy_o=1; go to WRITE.
  - First beat is visible in the cycle right after the start edge (1-cycle latency).
- IDLE with en=0: no change; outputs stay at 0, except addr/data, which hold their last values.
- WRITE, at each edge:
  - mem_gnt=1: current beat is accepted.
    - If idx<3: idx+1, addr=(base+idx+1) mod 2^ADDR_W, data=next snapshot word in order c11, c12, c21, c22; we stays 1.
    - If idx=3: we=0, busy_o=0, is_done_o=1; go to DONE.
  - mem_gnt=0: stall; idx, addr, data, we held unchanged; stall length unbounded.
- en deasserted during WRITE is ignored; the transaction always completes.
- Changes on c11..c22 or result_baseaddr after start have no effect on the current transaction.
- DONE: is_done_o=1 while en=1. At an edge with en=0: is_done_o=0; go to IDLE. This prevents retrigger while en is held high.
- Minimum transaction length: 4 write cycles with no stalls, plus 1 DONE cycle. is_done_o rises at the 5th edge after start.
- Address arithmetic: unsigned, ADDR_W-bit, wrap-around, no carry out. Example: base 62 gives 62, 63, 0, 1.
- Simultaneous events: a start and the DONE->IDLE transition cannot overlap. A new start requires en low for at least one edge after DONE.
- X/undefined c inputs only matter if sampled at start.

Test Plan:
- Basic: base=6'd10, c=8'h11/22/33/44, mem_gnt=1, en pulse held high. Required response:
  - we=1 for exactly 4 cycles with addr 10, 11, 12, 13 and data 11, 22, 33, 44.
  - is_done_o=1 on the next cycle, held until en=0; then busy_o=0 and is_done_o=0.
- Wrap: base=6'd62, c=1/2/3/4. Required: addr 62, 63, 0, 1 with data 1, 2, 3, 4.
- Stall: mem_gnt=0 for 3 cycles during beat idx=1. Required: addr and data held at base+1/c12 with we=1 for 4 cycles total; transaction completes after 7 write cycles.
- Snapshot: change all c inputs to 8'hFF and base to 0 in the cycle after start. Required: the original values and addresses are written.
- Reset abort: assert rst=0 during beat idx=2. Required: addr, we, data, busy_o, is_done_o go to 0 asynchronously (before the next edge); after release the block is in IDLE and a new start writes from idx=0.
- No retrigger: hold en=1 through DONE for 5 cycles. Required: exactly one 4-beat transaction; a second starts only after en goes low for at least 1 edge and then high again.
